// File: rtl/fator_pkg.sv
// Shared state encoding, default parameters and counter sizing helper for the
// factorizer request controller.
package fator_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StReq     = 2'd2,
    StRelease = 2'd3
  } fator_state_e;

  localparam int unsigned DefWidth        = 16;
  localparam int unsigned DefSettleCycles = 16;
  localparam int unsigned DefAckTimeout   = 65535;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fator_settle_cnt.sv
// Saturating settle counter: done marks the cycle on which the stable run
// reaches SETTLE_CYCLES samples.
module fator_settle_cnt
  import fator_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned CntW = cnt_width(SETTLE_CYCLES);

  logic [CntW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (32'(cnt) < SETTLE_CYCLES)) begin
      cnt <= cnt + CntW'(1);
    end
  end

  // Fires when this cycle's increment brings the count to SETTLE_CYCLES-1.
  assign done = en && !clr && ((32'(cnt) + 32'd2) >= SETTLE_CYCLES);

endmodule

// File: rtl/fator_req_ctrl.sv
// Switch-driven request controller: synchronizes and debounces sw_in, then
// runs a four-phase req/ack handshake with the factorizer engine.
module fator_req_ctrl
  import fator_pkg::*;
#(
  parameter int unsigned WIDTH         = DefWidth,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned ACK_TIMEOUT   = DefAckTimeout
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             ack,
  output logic             req,
  output logic [WIDTH-1:0] n_out,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned      TmoW    = cnt_width(ACK_TIMEOUT);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(ACK_TIMEOUT - 1);

  fator_state_e     state;
  logic [WIDTH-1:0] sw_meta;
  logic [WIDTH-1:0] sw_s;
  logic [WIDTH-1:0] cand;
  logic [TmoW-1:0]  tmo_cnt;
  logic             pwr_up;
  logic             settle_clr;
  logic             settle_en;
  logic             settle_done;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_s    <= sw_meta;
    end
  end

  // Counter is held clear outside SETTLE so every settle episode starts at 0.
  assign settle_en  = (state == StSettle) && (sw_s == cand);
  assign settle_clr = (state != StSettle) || (sw_s != cand);

  fator_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_cnt (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .clr     (settle_clr),
    .en      (settle_en),
    .done    (settle_done)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      req         <= 1'b0;
      busy        <= 1'b0;
      n_out       <= '0;
      timeout_err <= 1'b0;
      cand        <= '0;
      tmo_cnt     <= '0;
      pwr_up      <= 1'b1;
    end else begin
      case (state)
        StIdle: begin
          if ((sw_s != n_out) || pwr_up) begin
            state <= StSettle;
            cand  <= sw_s;
            busy  <= 1'b1;
          end
        end
        StSettle: begin
          if (sw_s != cand) begin
            cand <= sw_s;
          end else if (settle_done) begin
            n_out   <= cand;
            pwr_up  <= 1'b0;
            tmo_cnt <= '0;
            req     <= 1'b1;
            state   <= StReq;
          end
        end
        StReq: begin
          // ack wins over a timeout expiring on the same cycle.
          if (ack) begin
            req   <= 1'b0;
            state <= StRelease;
          end else if (tmo_cnt == TmoLast) begin
            req         <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
          end
        end
        StRelease: begin
          if (!ack) begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: begin
          req   <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fator_req_ctrl.sv
// Self-checking bench for fator_req_ctrl: directed handshake scenarios plus
// randomized switch/engine traffic against a cycle-level behavioural model.
module tb_fator_req_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;
  localparam int unsigned T = 50;

  logic         CLOCK_50 = 1'b0;
  logic         rst_n    = 1'b0;
  logic [W-1:0] sw_in    = 16'd360;
  logic         ack;
  logic         req;
  logic [W-1:0] n_out;
  logic         busy;
  logic         timeout_err;

  always #10 CLOCK_50 = ~CLOCK_50;

  fator_req_ctrl #(
    .WIDTH        (W),
    .SETTLE_CYCLES(S),
    .ACK_TIMEOUT  (T)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .ack        (ack),
    .req        (req),
    .n_out      (n_out),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 settling, 2 requesting, 3 releasing.
  int           m_phase = 0;
  int           m_run   = 0;
  int           m_wait  = 0;
  bit           m_err   = 1'b0;
  bit           m_pwr   = 1'b1;
  logic [W-1:0] m_s1    = '0;
  logic [W-1:0] m_s2    = '0;
  logic [W-1:0] m_n     = '0;
  logic [W-1:0] m_cand  = '0;

  always @(posedge CLOCK_50 or negedge rst_n) begin
    logic [W-1:0] smp;
    if (!rst_n) begin
      m_phase = 0; m_run = 0; m_wait = 0; m_err = 1'b0; m_pwr = 1'b1;
      m_s1 = '0; m_s2 = '0; m_n = '0; m_cand = '0;
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = sw_in;
      if (m_phase == 0) begin
        if (smp != m_n || m_pwr) begin
          m_phase = 1; m_cand = smp; m_run = 1;
        end
      end else if (m_phase == 1) begin
        if (smp == m_cand) begin
          m_run++;
          if (m_run >= int'(S)) begin
            m_n = m_cand; m_pwr = 1'b0; m_phase = 2; m_wait = 0;
          end
        end else begin
          m_cand = smp; m_run = 1;
        end
      end else if (m_phase == 2) begin
        m_wait++;
        if (ack) m_phase = 3;
        else if (m_wait >= int'(T)) begin
          m_err = 1'b1; m_phase = 0;
        end
      end else begin
        if (!ack) m_phase = 0;
      end
    end
  end

  int   n_rise   = 0;
  logic prev_req = 1'b0;

  always @(negedge CLOCK_50) begin
    check_eq("cyc_req", req, (m_phase == 2));
    check_eq("cyc_busy", busy, (m_phase != 0));
    check_eq("cyc_n_out", n_out, m_n);
    check_eq("cyc_timeout_err", timeout_err, m_err);
    if (req && !prev_req) n_rise++;
    prev_req = req;
  end

  // Engine: acks eng_delay cycles into a request, drops ack once req falls.
  int eng_delay = 10;
  bit eng_mute  = 1'b0;
  bit eng_force = 1'b0;

  initial begin
    int wait_cnt;
    ack = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge CLOCK_50);
      if (eng_force) begin
        ack = 1'b1;
      end else if (req === 1'b1) begin
        wait_cnt++;
        if (!eng_mute && wait_cnt >= eng_delay) ack = 1'b1;
      end else begin
        wait_cnt = 0;
        ack = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      #2;
    end
  endtask

  function automatic logic sig_of(input int sel);
    return (sel == 0) ? req : (sel == 1) ? ack : busy;
  endfunction

  task automatic wait_until(input int sel, input logic lvl, input int lim, input string tag,
                            output int waited);
    waited = 0;
    while (sig_of(sel) !== lvl && waited < lim) begin
      cyc(1);
      waited++;
    end
    check_eq(tag, sig_of(sel), lvl);
  endtask

  task automatic req_high_time(output int dur);
    dur = 0;
    while (req === 1'b1 && dur < 200) begin
      cyc(1);
      dur++;
    end
  endtask

  initial begin
    int w;
    int base;
    logic [W-1:0] pool [4];
    pool[0] = 16'd360; pool[1] = 16'd97; pool[2] = 16'd1001; pool[3] = 16'd65535;

    // Power-up request with 360.
    cyc(3);
    check_eq("rst_req", req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_n_out", n_out, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    wait_until(0, 1'b1, 20, "pwrup_req", w);
    check_eq("pwrup_latency", w, 2 + S);
    check_eq("pwrup_n_out", n_out, 360);
    wait_until(1, 1'b1, 20, "pwrup_ack", w);
    check_eq("req_at_ack", req, 1);
    cyc(1);
    check_eq("req_fall_after_ack", req, 0);
    cyc(1);
    check_eq("busy_after_ack_drop", busy, 0);
    cyc(5);

    // Toggling switch never settles.
    base = n_rise;
    for (int i = 0; i < 10; i++) begin
      sw_in = (i % 2 == 0) ? 16'd100 : 16'd101;
      cyc(2);
    end
    check_eq("toggle_no_req", n_rise - base, 0);
    wait_until(0, 1'b1, 20, "toggle_final_req", w);
    check_eq("toggle_n_out", n_out, 101);
    wait_until(2, 1'b0, 40, "toggle_done", w);
    cyc(10);
    check_eq("toggle_one_req", n_rise - base, 1);

    // Timeout, then a successful request keeps the sticky flag.
    eng_mute = 1'b1;
    sw_in = 16'd555;
    wait_until(0, 1'b1, 20, "tmo_req", w);
    req_high_time(w);
    check_eq("tmo_req_width", w, T);
    check_eq("tmo_flag", timeout_err, 1);
    eng_mute = 1'b0;
    cyc(3);
    sw_in = 16'd777;
    wait_until(0, 1'b1, 20, "post_tmo_req", w);
    wait_until(2, 1'b0, 40, "post_tmo_done", w);
    check_eq("post_tmo_n_out", n_out, 777);
    check_eq("tmo_flag_sticky", timeout_err, 1);

    // Switch change during REQ is deferred to a second request.
    base = n_rise;
    sw_in = 16'd360;
    wait_until(0, 1'b1, 20, "hold_req", w);
    check_eq("hold_n_out_first", n_out, 360);
    cyc(2);
    sw_in = 16'd97;
    cyc(3);
    check_eq("hold_n_out_in_req", n_out, 360);
    wait_until(0, 1'b0, 20, "hold_req_fall", w);
    wait_until(0, 1'b1, 40, "hold_second_req", w);
    check_eq("hold_n_out_second", n_out, 97);
    check_eq("hold_two_reqs", n_rise - base, 2);
    wait_until(2, 1'b0, 40, "hold_done", w);

    // Asynchronous reset mid-handshake.
    sw_in = 16'd1234;
    wait_until(0, 1'b1, 20, "areset_req", w);
    #3 rst_n = 1'b0;
    #1;
    check_eq("areset_req_drop", req, 0);
    check_eq("areset_busy", busy, 0);
    check_eq("areset_err_clear", timeout_err, 0);
    cyc(2);
    rst_n = 1'b1;
    wait_until(0, 1'b1, 20, "areset_new_req", w);
    check_eq("areset_latency", w, 2 + S);
    check_eq("areset_n_out", n_out, 1234);
    wait_until(0, 1'b0, 20, "areset_req_fall", w);
    wait_until(2, 1'b0, 20, "areset_done", w);

    // Stale ack while idle.
    base = n_rise;
    eng_force = 1'b1;
    cyc(5);
    eng_force = 1'b0;
    cyc(2);
    check_eq("stale_req", req, 0);
    check_eq("stale_busy", busy, 0);
    check_eq("stale_no_req", n_rise - base, 0);

    // ack arriving on the timeout cycle counts as success.
    eng_delay = T;
    sw_in = 16'd4321;
    wait_until(0, 1'b1, 20, "edge_req", w);
    req_high_time(w);
    check_eq("edge_req_width", w, T);
    check_eq("edge_no_tmo", timeout_err, 0);
    check_eq("edge_release_busy", busy, 1);
    cyc(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      sw_in     = pool[$urandom_range(0, 3)];
      eng_delay = int'($urandom_range(1, 60));
      eng_mute  = ($urandom_range(0, 9) == 0);
      cyc(int'($urandom_range(1, 14)));
    end
    eng_mute = 1'b0;
    cyc(150);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
